// File: rtl/sar_adc.sv
// Successive-approximation ADC with held input sample and a bit-serial SAR.
// Voltages are signed fixed-point words sharing one scale; vtrial shows the trial-DAC level for that scale.
module sar_adc #(
  parameter int                        BITS   = 4,
  parameter int                        DATA_W = 16,
  parameter logic signed [DATA_W-1:0] VOS    = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] ain,
  input  logic signed [DATA_W-1:0] vref,
  output logic [BITS-1:0]          dout,
  output logic                     valid,
  output logic                     busy,
  output logic signed [DATA_W-1:0] vtrial
);

  localparam int             PW  = DATA_W + BITS + 2;
  localparam int             KW  = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [BITS-1:0] MSB = BITS'(1) << (BITS - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                   state;
  logic [BITS-1:0]          trial;
  logic [KW-1:0]            k;
  logic signed [DATA_W-1:0] vin_h;
  logic signed [DATA_W-1:0] vr_h;
  logic                     ge;
  logic [BITS-1:0]          code_nxt;

  function automatic logic signed [PW-1:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(PW-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] zext(input logic [BITS-1:0] c);
    return {{(PW-BITS){1'b0}}, c};
  endfunction

  // Threshold test done on 2^BITS-scaled values, so no division and vref=0 is harmless.
  function automatic logic at_or_above(input logic signed [DATA_W-1:0] vin,
                                       input logic signed [DATA_W-1:0] vr,
                                       input logic [BITS-1:0]          code);
    logic signed [PW-1:0] lhs;
    logic signed [PW-1:0] rhs;
    lhs = sext(vin) <<< BITS;
    rhs = zext(code) * sext(vr) + (sext(VOS) <<< BITS);
    return lhs >= rhs;
  endfunction

  function automatic logic [BITS-1:0] clamp_code(input logic signed [DATA_W-1:0] vin,
                                                 input logic signed [DATA_W-1:0] vr,
                                                 input logic [BITS-1:0]          code);
    logic [BITS-1:0] c;
    if (vr[DATA_W-1] || (vr == '0))
      c = '0;
    else if (vin >= vr)
      c = '1;
    else if (vin[DATA_W-1])
      c = '0;
    else
      c = code;
    return c;
  endfunction

  function automatic logic signed [DATA_W-1:0] trial_level(input logic [BITS-1:0]          code,
                                                           input logic signed [DATA_W-1:0] vr);
    logic signed [PW-1:0] p;
    p = zext(code) * sext(vr);
    p = p >>> BITS;
    return p[DATA_W-1:0];
  endfunction

  always_comb begin
    ge       = at_or_above(vin_h, vr_h, trial);
    code_nxt = trial;
    code_nxt[k] = ge;
    if (k != '0)
      code_nxt[k - KW'(1)] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dout  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      trial <= '0;
      k     <= '0;
      vin_h <= '0;
      vr_h  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            vin_h <= ain;
            vr_h  <= vref;
            trial <= MSB;
            k     <= KW'(BITS - 1);
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          trial <= code_nxt;
          if (k != '0) begin
            k <= k - KW'(1);
          end else begin
            dout  <= clamp_code(vin_h, vr_h, code_nxt);
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vtrial = trial_level(trial, vr_h);

endmodule

// File: tb/tb_sar_adc.sv
// Directed bench for sar_adc (BITS=4, 1.0 V = 4096): scoreboard of expected codes, latency and control checks.
module tb_sar_adc;

  localparam int ONE = 4096;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [15:0] ain;
  logic signed [15:0] vref;
  logic [3:0]         dout;
  logic               valid;
  logic               busy;
  logic signed [15:0] vtrial;

  int checks = 0;
  int errors = 0;
  int sb[$];

  sar_adc #(.BITS(4), .DATA_W(16), .VOS(16'sd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ain   (ain),
    .vref  (vref),
    .dout  (dout),
    .valid (valid),
    .busy  (busy),
    .vtrial(vtrial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Result checker: every valid pulse pops one expected code.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        int e;
        e = sb.pop_front();
        chk("dout", 32'(dout), 32'(e));
      end
    end
  end

  // Called at a negedge with the DUT idle; checks the full bits+1 cycle timeline.
  task automatic convert(input int a, input int vr, input int e);
    ain   = 16'(a);
    vref  = 16'(vr);
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_first", 32'(busy), 32'd1);
    if (vr >= 0)
      chk("vtrial_msb", 32'(vtrial), 32'(vr / 2));
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("busy_conv", 32'(busy), 32'd1);
      chk("valid_conv", 32'(valid), 32'd0);
    end
    @(negedge clk);
    chk("valid_done", 32'(valid), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("valid_drop", 32'(valid), 32'd0);
  endtask

  initial begin
    int nv;
    rst_n = 1'b0;
    start = 1'b0;
    ain   = '0;
    vref  = '0;
    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vtrial", 32'(vtrial), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    convert(2048, ONE, 8);
    convert(1228, ONE, 4);
    convert(3840, ONE, 15);
    convert(4915, ONE, 15);
    convert(-410, ONE, 0);
    convert(2048, 0, 0);

    // start held high: accepted at edges 0, 5, 10
    ain   = 16'(1024);
    vref  = 16'(ONE);
    sb.push_back(4);
    sb.push_back(4);
    sb.push_back(4);
    start = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("held_valid", 32'(valid), (c == 4 || c == 9 || c == 14) ? 32'd1 : 32'd0);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_sb_empty", 32'(sb.size()), 32'd0);

    // start pulse while busy must not queue a second conversion
    ain   = 16'(3277);
    start = 1'b1;
    sb.push_back(12);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid === 1'b1) nv++;
    end
    chk("busy_start_ignored", 32'(nv), 32'd1);

    // reset aborts a conversion in flight
    ain   = 16'(2048);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_vtrial", 32'(vtrial), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_dout_hold", 32'(dout), 32'd0);
    convert(2048, ONE, 8);

    // input moves after the sample edge: held sample wins
    ain   = 16'(819);
    start = 1'b1;
    sb.push_back(3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    ain = 16'(3277);
    repeat (3) @(negedge clk);
    chk("held_sample_valid", 32'(valid), 32'd1);
    @(negedge clk);
    chk("held_sample_drop", 32'(valid), 32'd0);
    convert(3277, ONE, 12);

    // loopback through an ideal 4-bit DAC
    for (int d = 0; d < 16; d++) begin
      ain = 16'(d * ONE / 16);
      repeat (3) @(negedge clk);
      convert(d * ONE / 16, ONE, d);
    end

    repeat (4) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
